// File: rtl/flash_arb_pkg.sv
// Shared widths and FSM encoding for the two-requester flash op arbiter.
package flash_arb_pkg;

    localparam int TYP_W  = 2;
    localparam int ADDR_W = 24;
    localparam int NUM_W  = 9;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_win
);

    // i_ptr is the index of the last winner.
    always_comb begin
        o_win = i_req;
        if (i_req == 2'b11) begin
            o_win = i_ptr ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/flash_req_arbiter.sv
// Arbitrates two op/write/read requesters onto one flash_drive port; one op in flight at a time.
// Handshake: a transfer happens in a cycle where valid and ready are both 1; valid holds its payload until then.
module flash_req_arbiter
    import flash_arb_pkg::*;
#(
    parameter int P_RR_EN = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [2*TYP_W-1:0]    i_req_op_typ,
    input  logic [2*ADDR_W-1:0]   i_req_op_addr,
    input  logic [2*NUM_W-1:0]    i_req_op_num,
    input  logic [1:0]            i_req_op_valid,
    output logic [1:0]            o_req_op_ready,
    input  logic [2*DATA_W-1:0]   i_req_write_data,
    input  logic [1:0]            i_req_write_sop,
    input  logic [1:0]            i_req_write_eop,
    input  logic [1:0]            i_req_write_valid,
    output logic [2*DATA_W-1:0]   o_req_read_data,
    output logic [1:0]            o_req_read_sop,
    output logic [1:0]            o_req_read_eop,
    output logic [1:0]            o_req_read_valid,
    output logic [1:0]            o_grant,
    output logic [TYP_W-1:0]      o_op_typ,
    output logic [ADDR_W-1:0]     o_op_addr,
    output logic [NUM_W-1:0]      o_op_num,
    output logic                  o_op_valid,
    input  logic                  i_op_ready,
    output logic [DATA_W-1:0]     o_write_data,
    output logic                  o_write_sop,
    output logic                  o_write_eop,
    output logic                  o_write_valid,
    input  logic [DATA_W-1:0]     i_read_data,
    input  logic                  i_read_sop,
    input  logic                  i_read_eop,
    input  logic                  i_read_valid,
    output logic [1:0]            o_dbg_state
);

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic [1:0]          r_grant;
    logic                r_ptr;
    logic                r_busy;
    logic [TYP_W-1:0]    r_typ;
    logic [ADDR_W-1:0]   r_addr;
    logic [NUM_W-1:0]    r_num;
    logic [1:0]          w_win;
    logic                w_ptr;
    logic                w_arb_go;
    logic                w_done;
    logic                w_sel;
    logic                w_own;

    // Fixed priority is a round-robin whose pointer always says "req1 went last".
    assign w_ptr    = (P_RR_EN != 0) ? r_ptr : 1'b1;
    assign w_arb_go = (r_state == ST_IDLE) && i_op_ready && (|i_req_op_valid);
    assign w_done   = (r_state == ST_WAIT_DONE) && r_busy && i_op_ready;

    rr_arb2 u_rr_arb2 (
        .i_req (i_req_op_valid),
        .i_ptr (w_ptr),
        .o_win (w_win)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_arb_go)   w_next = ST_ISSUE;
            ST_ISSUE:     if (i_op_ready) w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (w_done)     w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_grant <= 2'b00;
            r_ptr   <= 1'b1;
            r_busy  <= 1'b0;
            r_typ   <= '0;
            r_addr  <= '0;
            r_num   <= '0;
        end else begin
            if (w_arb_go) begin
                r_grant <= w_win;
                r_typ   <= w_win[1] ? i_req_op_typ[2*TYP_W-1 -: TYP_W]   : i_req_op_typ[TYP_W-1:0];
                r_addr  <= w_win[1] ? i_req_op_addr[2*ADDR_W-1 -: ADDR_W] : i_req_op_addr[ADDR_W-1:0];
                r_num   <= w_win[1] ? i_req_op_num[2*NUM_W-1 -: NUM_W]   : i_req_op_num[NUM_W-1:0];
                r_ptr   <= w_win[1];
            end
            // Completion needs the drive to have gone busy first, then ready again.
            if (r_state == ST_WAIT_DONE) begin
                if (w_done) begin
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                end else if (!i_op_ready) begin
                    r_busy  <= 1'b1;
                end
            end
        end
    end

    assign w_sel = r_grant[1];
    assign w_own = |r_grant;

    always_comb begin
        o_req_op_ready = w_arb_go ? w_win : 2'b00;
        o_op_valid     = (r_state == ST_ISSUE);
        o_write_valid  = w_own & i_req_write_valid[w_sel];
        o_write_sop    = w_own & i_req_write_sop[w_sel];
        o_write_eop    = w_own & i_req_write_eop[w_sel];
        o_write_data   = '0;
        if (w_own) begin
            o_write_data = w_sel ? i_req_write_data[2*DATA_W-1 -: DATA_W] : i_req_write_data[DATA_W-1:0];
        end
    end

    assign o_grant          = r_grant;
    assign o_op_typ         = r_typ;
    assign o_op_addr        = r_addr;
    assign o_op_num         = r_num;
    assign o_req_read_data  = {2{i_read_data}};
    assign o_req_read_valid = r_grant & {2{i_read_valid}};
    assign o_req_read_sop   = r_grant & {2{i_read_sop}};
    assign o_req_read_eop   = r_grant & {2{i_read_eop}};
    assign o_dbg_state      = r_state;

endmodule
